// File: rtl/mmio_console.sv
// Memory-mapped console: captures putc writes into a character FIFO and
// latches the program exit code, raising exit_valid once the FIFO drains.
module mmio_console #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [31:0] PUTC_ADDR = 32'h9000001c,
    parameter logic [31:0] EXIT_ADDR = 32'h9000002c
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        req,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        hit,
    output logic        wvalid,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        exit_valid,
    output logic [31:0] exit_code,
    output logic [15:0] char_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t      state, state_next;
    logic [AW:0] wptr, rptr;
    logic [7:0]  mem [DEPTH];
    logic        putc_sel, exit_sel, putc_wr, full, empty, push, pop;

    assign putc_sel = req && (waddr == PUTC_ADDR);
    assign exit_sel = req && (waddr == EXIT_ADDR);
    assign putc_wr  = (state == RUN) && putc_sel && wstrb[0];

    // Extra pointer bit distinguishes full from empty when the low bits match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    assign push = putc_wr && !full;
    assign pop  = !empty && tx_ready;

    assign hit        = putc_sel || exit_sel;
    assign wvalid     = !(putc_wr && full);
    assign tx_valid   = !empty;
    assign tx_data    = mem[rptr[AW-1:0]];
    assign exit_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wptr       <= '0;
            rptr       <= '0;
            char_count <= '0;
            exit_code  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
                if (char_count != 16'hFFFF) begin
                    char_count <= char_count + 16'd1;
                end
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if ((state == RUN) && exit_sel) begin
                exit_code <= wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (exit_sel) state_next = DRAIN;
            DRAIN:   if (empty)    state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = RUN;
        endcase
    end
endmodule

// File: tb/tb_mmio_console.sv
// Randomized and directed bench for mmio_console; a queue-based reference
// model predicts handshakes while a monitor scoreboards the character stream.
module tb_mmio_console;
    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] PUTC  = 32'h9000001c;
    localparam logic [31:0] EXITA = 32'h9000002c;

    logic        clk;
    logic        resetb;
    logic        req;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        hit;
    logic        wvalid;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        exit_valid;
    logic [31:0] exit_code;
    logic [15:0] char_count;

    mmio_console #(
        .DEPTH(DEPTH),
        .PUTC_ADDR(PUTC),
        .EXIT_ADDR(EXITA)
    ) dut (
        .clk(clk),
        .resetb(resetb),
        .req(req),
        .waddr(waddr),
        .wdata(wdata),
        .wstrb(wstrb),
        .hit(hit),
        .wvalid(wvalid),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_data(tx_data),
        .exit_valid(exit_valid),
        .exit_code(exit_code),
        .char_count(char_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          vectors;
    int          miscompares;
    // Reference model: FIFO occupancy, accepted-character queue, exit status.
    logic [7:0]  exp_q[$];
    int          occ;
    bit          exited;
    bit          done;
    logic [31:0] code;
    int          cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        occ    = 0;
        exited = 0;
        done   = 0;
        code   = '0;
        cnt    = 0;
    endtask

    // Monitor: the head character must match the oldest accepted character.
    always @(negedge clk) begin
        if (resetb && tx_valid) begin
            if (exp_q.size() == 0) begin
                chk("tx_spurious", 32'(tx_valid), 32'd0);
            end else begin
                chk("tx_data", 32'(tx_data), 32'(exp_q[0]));
                if (tx_ready) void'(exp_q.pop_front());
            end
        end
    end

    // One cycle: drive after the edge, check at negedge, advance model at the edge.
    task automatic step(input logic r, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic tr);
        bit putc_w, mpush, mpop;
        req = r; waddr = a; wdata = d; wstrb = s; tx_ready = tr;
        @(negedge clk);
        putc_w = r && (a == PUTC) && s[0];
        chk("hit", 32'(hit), 32'(r && (a == PUTC || a == EXITA)));
        chk("wvalid", 32'(wvalid), 32'(!(!exited && putc_w && occ == DEPTH)));
        chk("tx_valid", 32'(tx_valid), 32'(occ > 0));
        chk("exit_valid", 32'(exit_valid), 32'(done));
        chk("exit_code", exit_code, code);
        chk("char_count", 32'(char_count), 32'(cnt));
        mpush = !exited && putc_w && (occ < DEPTH);
        mpop  = (occ > 0) && tr;
        @(posedge clk);
        if (exited && occ == 0) done = 1;
        if (!exited && r && a == EXITA) begin
            exited = 1;
            code   = d;
        end
        if (mpush) begin
            exp_q.push_back(d[7:0]);
            occ++;
            if (cnt < 65535) cnt++;
        end
        if (mpop) occ--;
        #1;
    endtask

    task automatic idle(input int n, input logic tr);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 4'd0, tr);
    endtask

    task automatic rand_phase(input int n, input bit allow_exit);
        for (int i = 0; i < n; i++) begin
            int unsigned sel;
            logic [31:0] a;
            logic        r;
            sel = $urandom_range(0, 9);
            r   = 1'b1;
            if (sel < 5)       a = PUTC;
            else if (sel < 7)  a = 32'($urandom);
            else if (sel == 7) a = PUTC + 32'd4;
            else begin
                a = PUTC;
                r = 1'b0;
            end
            if (allow_exit && $urandom_range(0, 59) == 0) a = EXITA;
            step(r, a, 32'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic async_reset();
        req = 1'b0;
        #2 resetb = 1'b0;
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_exit_valid", 32'(exit_valid), 32'd0);
        chk("rst_char_count", 32'(char_count), 32'd0);
        chk("rst_exit_code", exit_code, 32'd0);
        chk("rst_wvalid", 32'(wvalid), 32'd1);
        model_reset();
        @(posedge clk);
        #1 resetb = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();
        resetb = 1'b0; req = 1'b0; waddr = '0; wdata = '0; wstrb = '0; tx_ready = 1'b0;
        #12;
        chk("init_tx_valid", 32'(tx_valid), 32'd0);
        chk("init_exit_valid", 32'(exit_valid), 32'd0);
        chk("init_wvalid", 32'(wvalid), 32'd1);
        chk("init_char_count", 32'(char_count), 32'd0);
        resetb = 1'b1;
        @(posedge clk);
        #1;

        // "Hi" with the consumer always ready.
        step(1'b1, PUTC, 32'h48, 4'b0001, 1'b1);
        step(1'b1, PUTC, 32'h69, 4'b0001, 1'b1);
        idle(3, 1'b1);

        // Strobe without byte 0, and a neighbouring address.
        step(1'b1, PUTC, 32'h55, 4'b0010, 1'b1);
        step(1'b1, PUTC + 32'd4, 32'h56, 4'b0001, 1'b1);
        idle(2, 1'b1);

        rand_phase(300, 1'b0);
        idle(DEPTH + 4, 1'b1);

        // Fill the FIFO, stall the 17th write, free one slot, then retry.
        for (int i = 0; i < DEPTH; i++) step(1'b1, PUTC, 32'(8'h30 + i), 4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, PUTC, 32'h7A, 4'b0001, 1'b0);
        step(1'b1, PUTC, 32'h7A, 4'b0001, 1'b1);
        step(1'b1, PUTC, 32'h7A, 4'b0001, 1'b0);
        idle(DEPTH + 4, 1'b1);

        // Exit with three characters pending, then drain.
        for (int i = 0; i < 3; i++) step(1'b1, PUTC, 32'(8'h61 + i), 4'b0001, 1'b0);
        step(1'b1, EXITA, 32'h2A, 4'b0000, 1'b0);
        idle(3, 1'b0);
        idle(6, 1'b1);

        // Writes after termination are acknowledged and dropped.
        step(1'b1, PUTC, 32'h41, 4'b0001, 1'b1);
        step(1'b1, EXITA, 32'h99, 4'b1111, 1'b1);
        idle(2, 1'b1);

        // Reset while draining with five characters buffered.
        async_reset();
        for (int i = 0; i < 5; i++) step(1'b1, PUTC, 32'(8'h70 + i), 4'b0001, 1'b0);
        step(1'b1, EXITA, 32'h5, 4'b0001, 1'b0);
        idle(2, 1'b0);
        async_reset();
        idle(2, 1'b1);

        // Exit on a full FIFO is still accepted.
        for (int i = 0; i < DEPTH; i++) step(1'b1, PUTC, 32'($urandom), 4'b1111, 1'b0);
        step(1'b1, EXITA, 32'hDEAD_BEEF, 4'b0000, 1'b0);
        idle(DEPTH + 4, 1'b1);

        async_reset();
        rand_phase(400, 1'b1);
        idle(DEPTH + 4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mmio_console.md
MMIO_CONSOLE -- requirements
Module: mmio_console

Interface
REQ-001 SHALL have parameter DEPTH, default 16, console FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter PUTC_ADDR, default 32'h9000001c, character-output address.
REQ-003 SHALL have parameter EXIT_ADDR, default 32'h9000002c, program-exit address.
REQ-004 SHALL have port clk input 1, rising-edge clock.
REQ-005 SHALL have port resetb input 1, asynchronous active-low reset.
REQ-006 SHALL have port req input 1, core data-write request (dmem_wready).
REQ-007 SHALL have port waddr input 32, write byte address.
REQ-008 SHALL have port wdata input 32, write data.
REQ-009 SHALL have port wstrb input 4, write byte strobes.
REQ-010 SHALL have port hit output 1, write targets PUTC_ADDR or EXIT_ADDR (memory write-enable gate).
REQ-011 SHALL have port wvalid output 1, write accepted this cycle; low means core must hold the write.
REQ-012 SHALL have port tx_valid output 1, character available.
REQ-013 SHALL have port tx_ready input 1, consumer takes character.
REQ-014 SHALL have port tx_data output 8, character at FIFO head.
REQ-015 SHALL have port exit_valid output 1, program terminated and console drained.
REQ-016 SHALL have port exit_code output 32, value written to EXIT_ADDR.
REQ-017 SHALL have port char_count output 16, characters accepted since reset.

Function
REQ-018 hit SHALL be combinational: req && (waddr==PUTC_ADDR || waddr==EXIT_ADDR).
REQ-019 wvalid SHALL be combinational: 0 only when state RUN, req, waddr==PUTC_ADDR, wstrb[0]=1 and FIFO full; otherwise 1.
REQ-020 A putc push SHALL occur on a rising edge when state RUN, req, waddr==PUTC_ADDR, wstrb[0]=1 and FIFO not full; data = wdata[7:0].
REQ-021 A putc write with wstrb[0]=0 SHALL be acknowledged (wvalid=1) and discarded.
REQ-022 FIFO SHALL use read/write pointers of width log2(DEPTH)+1 with natural wrap; full = MSBs differ, low bits equal; empty = pointers equal.
REQ-023 A push SHALL be blocked when full even if a pop occurs the same cycle; push and pop in the same non-full, non-empty cycle SHALL both occur, occupancy unchanged.
REQ-024 tx_valid SHALL equal !empty; tx_data SHALL be the head entry combinationally; pop on tx_valid && tx_ready.
REQ-025 tx_data SHALL be stable while tx_valid=1 and tx_ready=0.
REQ-026 Push-to-tx_valid latency SHALL be 1 cycle (visible the cycle after the push edge).
REQ-027 char_count SHALL increment by 1 per push and saturate at 16'hFFFF.
REQ-028 State machine SHALL have states RUN, DRAIN, DONE.
REQ-029 RUN -> DRAIN on req && waddr==EXIT_ADDR (wstrb ignored); exit_code <= wdata on that edge.
REQ-030 A simultaneous putc cannot occur (single write port); an exit write SHALL be accepted even when the FIFO is full.
REQ-031 In DRAIN and DONE, putc and exit writes SHALL be acknowledged (wvalid=1) and discarded; exit_code SHALL not change.
REQ-032 DRAIN -> DONE on the edge where the FIFO is empty (including empty on entry: DONE one cycle after exit write).
REQ-033 exit_valid SHALL be 1 exactly in DONE and held until reset.
REQ-034 Writes to other addresses SHALL be ignored; hit=0, wvalid=1.

Reset
REQ-035 On resetb low, asynchronously: state RUN, pointers 0, exit_code 0, char_count 0; hence tx_valid 0, exit_valid 0, wvalid 1; tx_data is don't-care while tx_valid=0.
REQ-036 Reset mid-DRAIN or with FIFO non-empty SHALL discard all buffered characters.

Verification
REQ-037 Putc 'H','i' (wdata 0x48, 0x69, wstrb 0001), tx_ready=1 -> tx_data 0x48 then 0x69, each one cycle after push; char_count=2.
REQ-038 tx_ready=0, 17 putc writes (DEPTH 16) -> 16 accepted, 17th sees wvalid=0 until one pop, then accepted; drain order preserved.
REQ-039 3 chars queued, tx_ready=0, write 0x0000002A to EXIT_ADDR -> exit_valid stays 0; raise tx_ready -> exit_valid=1 one cycle after last pop, exit_code=0x2A.
REQ-040 In DONE, putc 0x41 and exit 0x99 -> wvalid=1, tx_valid stays 0, exit_code stays 0x2A, char_count unchanged.
REQ-041 Putc with wstrb=0010 and write to 0x9000001c+4 -> no push, hit=0 for the second only, wvalid=1 both.
REQ-042 Assert resetb low with 5 chars queued in DRAIN -> tx_valid=0, exit_valid=0, char_count=0 immediately, without waiting for a clock edge.
